apb_master_bridge: RTL and testbench

//  APB initiator: converts a simple valid/ready command port into APB3-style SETUP/ACCESS transfers
//  (no PSLVERR), and returns read data and status on a one-cycle response strobe.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/apb_master_bridge.sv | 157 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB bridge encodings: FSM state codes and transfer direction.
package apb_pkg;

   typedef logic [1:0] apb_state_t;

   localparam apb_state_t APB_IDLE   = 2'b00;
   localparam apb_state_t APB_SETUP  = 2'b01;
   localparam apb_state_t APB_ACCESS = 2'b10;

   localparam logic APB_READ  = 1'b0;
   localparam logic APB_WRITE = 1'b1;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired is registered and flags the last allowed wait cycle.
module apb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates once expired so an ignored abort cannot wrap the count
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt_q   <= '0;
         expired <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         expired <= (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 SETUP/ACCESS initiator with one-cycle response strobe.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 2");
   end

   apb_state_t            state_q, state_d;
   logic                  timeout_abort;
   logic                  psel_d, penable_d, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_d;
   logic                  rsp_valid_d, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
   logic to_expired;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .clear   (state_q == APB_SETUP),
      .inc     ((state_q == APB_ACCESS) && !PREADY),
      .expired (to_expired)
   );

   // PREADY on the final cycle wins over the abort
   assign timeout_abort = (state_q == APB_ACCESS) && !PREADY && to_expired;
`else
   assign timeout_abort = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= APB_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         PSEL      <= psel_d;
         PENABLE   <= penable_d;
         PWRITE    <= pwrite_d;
         PADDR     <= paddr_d;
         PWDATA    <= pwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         APB_IDLE:   if (cmd_valid) state_d = APB_SETUP;
         APB_SETUP:  state_d = APB_ACCESS;
         APB_ACCESS: begin
            if (PREADY) begin
               state_d = cmd_valid ? APB_SETUP : APB_IDLE;
            end else if (timeout_abort) begin
               state_d = APB_IDLE;
            end
         end
         default:    state_d = APB_IDLE;
      endcase
   end

   // Output next values and combinational cmd_ready
   always_comb begin
      cmd_ready   = 1'b0;
      psel_d      = PSEL;
      penable_d   = PENABLE;
      pwrite_d    = PWRITE;
      paddr_d     = PADDR;
      pwdata_d    = PWDATA;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      case (state_q)
         APB_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
            end
         end
         APB_SETUP: begin
            penable_d = 1'b1;
         end
         APB_ACCESS: begin
            cmd_ready = PREADY;
            if (PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = (PWRITE == APB_WRITE) ? '0 : PRDATA;
               rsp_err_d   = 1'b0;
               penable_d   = 1'b0;
               if (cmd_valid) begin
                  psel_d   = 1'b1;
                  pwrite_d = cmd_write;
                  paddr_d  = cmd_addr;
                  pwdata_d = cmd_wdata;
               end else begin
                  psel_d   = 1'b0;
               end
            end else if (timeout_abort) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transfers plus
// back-to-back, mid-transfer reset and timeout / no-timeout sequences.
module tb_apb_master_bridge;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;

   int n_vec = 0;
   int n_err = 0;

   always #5 PCLK = ~PCLK;

   apb_master_bridge #(
      .ADDR_WIDTH     (8),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Single transfer from IDLE with the given number of wait states
   task automatic do_xfer(input vec_t v);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      PREADY    = 1'b0;
      PRDATA    = 32'hFFFF_FFFF;
      #1 chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = 32'h0BAD_0BAD;
      chk("setup_psel_pen", {30'd0, PSEL, PENABLE}, 32'b10);
      chk("setup_paddr", 32'(PADDR), 32'(v.addr));
      chk("setup_pwrite", 32'(PWRITE), 32'(v.wr));
      chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
      if (v.wr) chk("setup_pwdata", PWDATA, v.wdata);
      tick();
      for (int k = 0; k <= v.waits; k++) begin
         chk("access_psel_pen_rsp", {29'd0, PSEL, PENABLE, rsp_valid}, 32'b110);
         chk("access_paddr", 32'(PADDR), 32'(v.addr));
         PREADY = (k == v.waits);
         PRDATA = (k == v.waits) ? v.prdata : 32'hFFFF_FFFF;
         tick();
      end
      PREADY = 1'b0;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("end_psel_pen", {30'd0, PSEL, PENABLE}, 32'b00);
      chk("end_paddr_hold", 32'(PADDR), 32'(v.addr));
      tick();
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h55AA_55AA, 32'h0000_0000};
      vecs[1] = '{1'b0, 8'h20, 32'h0,         2, 32'hCAFE_0001, 32'hCAFE_0001};
      vecs[2] = '{1'b1, 8'hFF, 32'h1234_5678, 1, 32'h55AA_55AA, 32'h0000_0000};
      vecs[3] = '{1'b0, 8'h00, 32'h0,         0, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[4] = '{1'b0, 8'h7F, 32'h0,         3, 32'h0000_FFFF, 32'h0000_FFFF};
      vecs[5] = '{1'b1, 8'h04, 32'h00C0_FFEE, 0, 32'h55AA_55AA, 32'h0000_0000};

      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PREADY    = 1'b0;
      PRDATA    = '0;
      tick();
      tick();
      chk("reset_ctrl", {27'd0, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 32'd0);
      chk("reset_paddr", 32'(PADDR), 32'd0);
      chk("reset_pwdata", PWDATA, 32'd0);
      chk("reset_rdata", rsp_rdata, 32'd0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      PRESET = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

      // Back-to-back: write 0x04 then read 0x04 held valid
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'h1122_3344;
      tick();
      cmd_write = 1'b0; cmd_wdata = 32'h0;
      chk("b2b_setup1", {29'd0, PSEL, PENABLE, PWRITE}, 32'b101);
      tick();
      PREADY = 1'b1;
      #1 chk("b2b_ready_access", 32'(cmd_ready), 32'd1);
      chk("b2b_access1", {30'd0, PSEL, PENABLE}, 32'b11);
      tick();
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      chk("b2b_setup2", {28'd0, rsp_valid, PSEL, PENABLE, PWRITE}, 32'b1100);
      chk("b2b_paddr2", 32'(PADDR), 32'h04);
      chk("b2b_wr_rdata", rsp_rdata, 32'h0);
      tick();
      chk("b2b_access2", {29'd0, PSEL, PENABLE, rsp_valid}, 32'b110);
      PREADY = 1'b1;
      PRDATA = 32'h1122_3344;
      tick();
      PREADY = 1'b0;
      chk("b2b_rd_rsp", {30'd0, rsp_valid, PSEL}, 32'b10);
      chk("b2b_rd_rdata", rsp_rdata, 32'h1122_3344);
      tick();

      // Reset while ACCESS is waiting
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("rst_mid_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
      PRESET = 1'b1;
      PREADY = 1'b1;
      tick();
      PRESET = 1'b0;
      PREADY = 1'b0;
      chk("rst_mid_ctrl", {29'd0, PSEL, PENABLE, rsp_valid}, 32'b000);
      chk("rst_mid_paddr", 32'(PADDR), 32'd0);
      #1 chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef APB_TIMEOUT_EN
      // PREADY stuck low: abort after 4 ACCESS cycles
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("to_access_hold", {29'd0, PSEL, PENABLE, rsp_valid}, 32'b110);
         if (k == 3) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50;
            #1 chk("to_no_accept", 32'(cmd_ready), 32'd0);
         end
         tick();
      end
      cmd_valid = 1'b0;
      chk("to_abort_rsp", {28'd0, rsp_valid, rsp_err, PSEL, PENABLE}, 32'b1100);
      chk("to_abort_rdata", rsp_rdata, 32'd0);
      tick();
      chk("to_err_hold", {30'd0, rsp_valid, rsp_err}, 32'b01);
      // PREADY on the 4th ACCESS cycle completes normally
      do_xfer('{1'b0, 8'h41, 32'h0, 3, 32'h0BEE_F00D, 32'h0BEE_F00D});
`else
      // PREADY low 100 cycles: master keeps waiting
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h60;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < 100; k++) begin
         if (k % 10 == 0)
            chk("noto_hold", {28'd0, PSEL, PENABLE, rsp_valid, rsp_err}, 32'b1100);
         tick();
      end
      chk("noto_paddr", 32'(PADDR), 32'h60);
      PREADY = 1'b1;
      PRDATA = 32'h0000_600D;
      tick();
      PREADY = 1'b0;
      chk("noto_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
      chk("noto_rdata", rsp_rdata, 32'h0000_600D);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
